qracc_bitserial_mac_seq: RTL and testbench
==========================================

// Module: qracc_bitserial_mac_seq
// PURPOSE
//  Bit-serial MAC sequencer for the analog QR accelerator macro.
//  - Accepts one vector of numRows signed multi-bit activations. Drives the macro one bit-plane per cycle.
//  - Shift-adds the per-column signed ADC codes into one signed result per column.
//  - Sits between the activation buffer and the accelerator wrapper. Owns mac_en, data_p and data_n.
// PARAMETERS
//  numRows     128  macro rows = activations per vector
//  numCols     32   macro columns = results per vector
//  numAdcBits  4    signed ADC code width (range -8..7)
//  inBits      4    signed two's-complement activation width (>=2)
//  accBits     numAdcBits+inBits  signed result width; fits the full range, no saturation
// PORTS
//  clk          in   1                       clock
//  rst          in   1                       synchronous reset, active-high
//  in_valid_i   in   1                       activation vector valid
//  in_ready_o   out  1                       sequencer can accept a vector
//  act_i        in   numRows*inBits          packed signed activations; row r = act_i[r]
//  mac_en_o     out  1                       to wrapper mac_en_i
//  data_p_o     out  numRows                 to wrapper data_p_i
//  data_n_o     out  numRows                 to wrapper data_n_i
//  adc_i        in   numCols*numAdcBits      from wrapper adc_out_o; signed code per column
//  out_valid_o  out  1                       result vector valid
//  out_ready_i  in   1                       consumer accepts result
//  result_o     out  numCols*accBits         signed accumulated result per column
//  busy_o       out  1                       high outside IDLE; SRAM-side arbitration uses it to block macro writes
// BEHAVIOUR
//  Reset (rst sampled high at posedge): state IDLE; all outputs 0 except in_ready_o=1; accumulators cleared.
//  States:
//  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, latch act_i, clear acc, plane b=0, go to COMPUTE.
//  - COMPUTE: one plane per cycle, b = 0..inBits-1.
//    - data_p_o[r] = act[r][b]; data_n_o = 0; mac_en_o = 1.
//    - After plane inBits-1, go to DRAIN.
//  - DRAIN: one cycle. mac_en_o=0; data_p_o=data_n_o=0. Go to DONE.
//  - DONE: out_valid_o=1; result_o held stable. On out_ready_i, go to IDLE.
//  data_p_o, data_n_o and mac_en_o are 0 in every state except COMPUTE.
//  Accumulation timing:
//  - The wrapper registers the ADC code, so the code for a plane driven in cycle k is on adc_i in cycle k+1.
//  - A one-deep pipeline register carries (plane index, valid) alongside that code.
//  - Update: acc[c] += sext(adc[c]) << b for b < inBits-1; acc[c] -= sext(adc[c]) << (inBits-1) for the MSB plane.
//  - Shift and sign-extend to accBits before add/subtract.
//  - The last plane's code is accumulated during DRAIN.
//  Latency (no skipping): accept in cycle 0; mac_en_o high in cycles 1..inBits; out_valid_o high from cycle inBits+2.
//  Throughput: one vector per inBits+3 cycles minimum.
//  Handshakes:
//  - in_ready_o=0 in every state but IDLE; in_valid_i in those states is ignored and not latched.
//  - Backpressure: in DONE with out_ready_i=0, out_valid_o and result_o hold indefinitely.
//  - out_ready_i high while out_valid_o=0 has no effect.
//  - out_valid_o drops the cycle after the handshake; there is no same-cycle re-accept.
//  Reset mid-operation: abort immediately to IDLE; mac_en_o=0 in the following cycle; the partial result is discarded.
//  Activation value 0: that row sits at VRST for every plane, contributing 0.
// CONFIGURATION
//  QRACC_SKIP_ZERO_PLANE_EN:
//  - Defined: in COMPUTE, a plane whose bits are all 0 across rows is skipped in 0 cycles (combinational next-nonzero-plane search).
//    - Skipped planes add nothing to acc.
//    - Both the first and the last issued plane obey the skip rule.
//    - If all planes are zero, go IDLE->DRAIN directly with result 0.
//    - DRAIN and DONE are unchanged.
//  - Undefined: every plane is issued; latency is fixed.
// TESTING
//  inBits=4; bench ADC model returns code 3 on all columns for every plane; all act=-1 (planes all 1)
//    -> result=3*(1+2+4)-3*8=-3 in every column; mac_en_o high exactly 4 cycles; out_valid_o at cycle 6.
//  ADC model returns plane codes {b0:1,b1:0,b2:0,b3:-1}; any act with all planes nonzero -> result=1+8=9.
//  ADC code 7 every plane -> -7; ADC code -8 every plane -> -8*7+64=8 (check sign-extension, no overflow).
//  out_ready_i held low 5 cycles in DONE -> out_valid_o and result_o stable; in_ready_o=0; a second in_valid_i is not accepted until after the handshake.
//  rst pulsed in cycle 2 of COMPUTE -> next cycle mac_en_o=0, busy_o=0, in_ready_o=1; a following vector yields a clean result.
//  All act=1 (only plane 0 set), ADC code 5 -> result 5.
//    - With QRACC_SKIP_ZERO_PLANE_EN: one mac_en_o pulse, out_valid_o at cycle 3.
//    - Without it: four pulses, out_valid_o at cycle 6.

Source files
------------

// File: rtl/qracc_bitserial_mac_seq_if.sv
// Activation-in / macro-drive / result-out bundle around the bit-serial MAC sequencer.
// master = sequencer side; slave = activation buffer, macro wrapper and result consumer.
interface qracc_bitserial_mac_seq_if #(
  parameter int numRows    = 128,
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int inBits     = 4
);
  localparam int accBits = numAdcBits + inBits;

  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [numRows*inBits-1:0]     act_i;
  logic                          mac_en_o;
  logic [numRows-1:0]            data_p_o;
  logic [numRows-1:0]            data_n_o;
  logic [numCols*numAdcBits-1:0] adc_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [numCols*accBits-1:0]    result_o;
  logic                          busy_o;

  modport master (
    input  in_valid_i, act_i, adc_i, out_ready_i,
    output in_ready_o, mac_en_o, data_p_o, data_n_o, out_valid_o, result_o, busy_o
  );

  modport slave (
    output in_valid_i, act_i, adc_i, out_ready_i,
    input  in_ready_o, mac_en_o, data_p_o, data_n_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/qracc_bitserial_mac_seq.sv
// Bit-serial MAC sequencer: drives one activation bit-plane per cycle, shift-adds signed ADC codes per column.
// Latency: accept in cycle 0, out_valid from cycle inBits+2; QRACC_SKIP_ZERO_PLANE_EN skips all-zero planes.
// Backpressure: one vector in flight; result held in DONE until out_ready_i, in_ready_o low outside IDLE.
module qracc_bitserial_mac_seq #(
  parameter int numRows    = 128,
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int inBits     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  qracc_bitserial_mac_seq_if.master bus
);
  localparam int accBits = numAdcBits + inBits;
  localparam int BW      = $clog2(inBits);
  localparam logic [BW-1:0] LAST_PLANE = BW'(inBits - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [numRows*inBits-1:0] act_q, act_d;
  logic [BW-1:0]             plane_q, plane_d;
  logic [BW-1:0]             pipe_b_q, pipe_b_d;
  logic                      pipe_vld_q, pipe_vld_d;
  logic                      mac_en_q, mac_en_d;
  logic [numRows-1:0]        data_p_q, data_p_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic signed [accBits-1:0] acc_q [numCols];
  logic signed [accBits-1:0] acc_d [numCols];
  logic [inBits-1:0]         in_nz, act_nz;
  logic [BW:0]               in_pick, act_pick;

  function automatic logic [numRows-1:0] plane_bits(input logic [numRows*inBits-1:0] a,
                                                    input logic [BW-1:0] b);
    logic [numRows-1:0] p;
    for (int r = 0; r < numRows; r++) p[r] = a[r*inBits + int'(b)];
    return p;
  endfunction

  // {found, index} of the lowest plane at or above start whose mask bit is set
  function automatic logic [BW:0] pick_plane(input logic [inBits-1:0] m, input int start);
    logic [BW:0] r;
    r = '0;
    for (int b = inBits - 1; b >= 0; b--)
      if (b >= start && m[b]) r = {1'b1, BW'(b)};
    return r;
  endfunction

  function automatic logic signed [accBits-1:0] weighted(input logic [numAdcBits-1:0] code,
                                                         input logic [BW-1:0] b);
    logic signed [accBits-1:0] x;
    x = {{(accBits-numAdcBits){code[numAdcBits-1]}}, code};
    return x <<< b;
  endfunction

`ifdef QRACC_SKIP_ZERO_PLANE_EN
  always_comb begin
    in_nz  = '0;
    act_nz = '0;
    for (int b = 0; b < inBits; b++) begin
      in_nz[b]  = |plane_bits(bus.act_i, BW'(b));
      act_nz[b] = |plane_bits(act_q, BW'(b));
    end
  end
`else
  assign in_nz  = '1;
  assign act_nz = '1;
`endif

  assign in_pick  = pick_plane(in_nz, 0);
  assign act_pick = pick_plane(act_nz, int'(plane_q) + 1);

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    plane_d    = plane_q;
    data_p_d   = '0;
    mac_en_d   = 1'b0;
    pipe_vld_d = mac_en_q;
    pipe_b_d   = plane_q;
    // ADC code on adc_i belongs to the plane driven one cycle earlier; MSB plane carries negative weight
    for (int c = 0; c < numCols; c++) begin
      acc_d[c] = acc_q[c];
      if (pipe_vld_q) begin
        if (pipe_b_q == LAST_PLANE)
          acc_d[c] = acc_q[c] - weighted(bus.adc_i[c*numAdcBits +: numAdcBits], pipe_b_q);
        else
          acc_d[c] = acc_q[c] + weighted(bus.adc_i[c*numAdcBits +: numAdcBits], pipe_b_q);
      end
    end
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          act_d = bus.act_i;
          for (int c = 0; c < numCols; c++) acc_d[c] = '0;
          if (in_pick[BW]) begin
            plane_d  = in_pick[BW-1:0];
            data_p_d = plane_bits(bus.act_i, in_pick[BW-1:0]);
            mac_en_d = 1'b1;
            state_d  = COMPUTE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      COMPUTE: begin
        if (act_pick[BW]) begin
          plane_d  = act_pick[BW-1:0];
          data_p_d = plane_bits(act_q, act_pick[BW-1:0]);
          mac_en_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      plane_q     <= '0;
      pipe_b_q    <= '0;
      pipe_vld_q  <= 1'b0;
      mac_en_q    <= 1'b0;
      data_p_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < numCols; c++) acc_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      plane_q     <= plane_d;
      pipe_b_q    <= pipe_b_d;
      pipe_vld_q  <= pipe_vld_d;
      mac_en_q    <= mac_en_d;
      data_p_q    <= data_p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int c = 0; c < numCols; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.mac_en_o    = mac_en_q;
  assign bus.data_p_o    = data_p_q;
  assign bus.data_n_o    = '0;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = busy_q;

  for (genvar c = 0; c < numCols; c++) begin : g_res
    assign bus.result_o[c*accBits +: accBits] = acc_q[c];
  end
endmodule

// File: tb/tb_qracc_bitserial_mac_seq.sv
// Bench for qracc_bitserial_mac_seq: registered ADC wrapper model plus a plane-sum reference model.
module tb_qracc_bitserial_mac_seq;
  localparam int NR  = 128;
  localparam int NC  = 32;
  localparam int AB  = 4;
  localparam int IB  = 4;
  localparam int ACC = AB + IB;
`ifdef QRACC_SKIP_ZERO_PLANE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [IB-1:0]      act_fill;
    logic [IB*AB-1:0]   codes;     // plane b code at [b*AB +: AB]
    logic signed [15:0] res;
    logic [7:0]         pulses;
    logic [7:0]         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qracc_bitserial_mac_seq_if #(.numRows(NR), .numCols(NC), .numAdcBits(AB), .inBits(IB)) bus ();
  qracc_bitserial_mac_seq #(.numRows(NR), .numCols(NC), .numAdcBits(AB), .inBits(IB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [NR*IB-1:0]     act_cur;
  logic signed [AB-1:0] codes_tb [IB][NC];
  int                   iss_plane [IB];
  int                   n_iss = 0;
  logic [NC*ACC-1:0]    exp_vec;
  int                   exp_pulses, exp_lat;
  int                   pulse = 0;
  int                   dp_err = 0;
  int                   n_chk = 0;
  int                   n_pass = 0;

  function automatic logic [NR-1:0] plane_of(input logic [NR*IB-1:0] a, input int b);
    logic [NR-1:0] p;
    for (int r = 0; r < NR; r++) p[r] = a[r*IB + b];
    return p;
  endfunction

  // A plane with no bit set leaves every row at VRST, so the macro returns code 0
  function automatic logic [NC*AB-1:0] adc_for(input int p);
    logic [NC*AB-1:0] v;
    v = '0;
    if (p < n_iss && bus.data_p_o != '0)
      for (int c = 0; c < NC; c++) v[c*AB +: AB] = codes_tb[iss_plane[p]][c];
    return v;
  endfunction

  // Wrapper model: registers the code for the plane driven this cycle; junk when mac_en is low
  always @(posedge clk) begin
    if (bus.in_valid_i && bus.in_ready_o) pulse <= 0;
    else if (bus.mac_en_o) pulse <= pulse + 1;
    if (bus.data_n_o != '0) dp_err <= dp_err + 1;
    else if (!bus.mac_en_o && bus.data_p_o != '0) dp_err <= dp_err + 1;
    else if (bus.mac_en_o && (pulse >= n_iss ||
             bus.data_p_o != plane_of(act_cur, iss_plane[pulse % IB]))) dp_err <= dp_err + 1;
    if (bus.mac_en_o) bus.adc_i <= adc_for(pulse);
    else bus.adc_i <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic check(input string nm, input logic [NC*ACC-1:0] got, input logic [NC*ACC-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  // Reference: result = sum over nonzero planes of code * 2^b, MSB plane weighted -2^(IB-1)
  task automatic set_expect();
    int s;
    n_iss = 0;
    for (int b = 0; b < IB; b++)
      if (!SKIP || plane_of(act_cur, b) != '0) begin
        iss_plane[n_iss] = b;
        n_iss++;
      end
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int b = 0; b < IB; b++)
        if (plane_of(act_cur, b) != '0)
          s += int'(codes_tb[b][c]) * ((b == IB - 1) ? -(1 << b) : (1 << b));
      exp_vec[c*ACC +: ACC] = ACC'(s);
    end
    exp_pulses = n_iss;
    exp_lat    = (n_iss == 0) ? 2 : n_iss + 2;
  endtask

  task automatic run_vec(input string nm, input int hold, input bit noisy);
    int                cyc, pulses, lat, err0;
    bit                stable;
    logic [NC*ACC-1:0] held;
    err0 = dp_err;
    bus.in_valid_i = 1'b1;
    bus.act_i      = act_cur;
    check({nm, ":in_ready"}, bus.in_ready_o, 1);
    @(negedge clk);
    bus.in_valid_i = noisy;
    bus.act_i      = noisy ? ~act_cur : act_cur;
    pulses = 0;
    lat    = -1;
    cyc    = 1;
    while (cyc < 40 && lat < 0) begin
      if (bus.out_valid_o) lat = cyc;
      else begin
        if (bus.mac_en_o) pulses++;
        @(negedge clk);
        cyc++;
      end
    end
    check({nm, ":latency"}, lat, exp_lat);
    check({nm, ":pulses"}, pulses, exp_pulses);
    check({nm, ":result"}, bus.result_o, exp_vec);
    check({nm, ":done_flags"}, {bus.busy_o, bus.in_ready_o, bus.mac_en_o}, 3'b100);
    held   = bus.result_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.out_valid_o || bus.result_o !== held || bus.in_ready_o) stable = 1'b0;
    end
    if (hold > 0) check({nm, ":hold"}, stable, 1);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b0;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check({nm, ":after_hs"}, {bus.out_valid_o, bus.in_ready_o, bus.busy_o}, 3'b010);
    check({nm, ":drive"}, dp_err - err0, 0);
  endtask

  task automatic fill_codes(input logic [IB*AB-1:0] cv);
    for (int b = 0; b < IB; b++)
      for (int c = 0; c < NC; c++) codes_tb[b][c] = cv[b*AB +: AB];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [9];
    logic [IB-1:0] pm;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.act_i       = '0;
    act_cur         = '0;
    exp_vec         = '0;
    fill_codes('0);

    tbl[0] = '{act_fill: 4'hF, codes: 16'h3333, res: -16'sd3, pulses: 8'd4, lat: 8'd6};
    tbl[1] = '{act_fill: 4'hF, codes: 16'hF001, res: 16'sd9, pulses: 8'd4, lat: 8'd6};
    tbl[2] = '{act_fill: 4'hF, codes: 16'h7777, res: -16'sd7, pulses: 8'd4, lat: 8'd6};
    tbl[3] = '{act_fill: 4'hF, codes: 16'h8888, res: 16'sd8, pulses: 8'd4, lat: 8'd6};
    tbl[4] = '{act_fill: 4'h1, codes: 16'h5555, res: 16'sd5,
               pulses: SKIP ? 8'd1 : 8'd4, lat: SKIP ? 8'd3 : 8'd6};
    tbl[5] = '{act_fill: 4'h0, codes: 16'h5555, res: 16'sd0,
               pulses: SKIP ? 8'd0 : 8'd4, lat: SKIP ? 8'd2 : 8'd6};
    tbl[6] = '{act_fill: 4'h4, codes: 16'h2222, res: 16'sd8,
               pulses: SKIP ? 8'd1 : 8'd4, lat: SKIP ? 8'd3 : 8'd6};
    tbl[7] = '{act_fill: 4'h8, codes: 16'hDDDD, res: 16'sd24,
               pulses: SKIP ? 8'd1 : 8'd4, lat: SKIP ? 8'd3 : 8'd6};
    tbl[8] = '{act_fill: 4'h5, codes: 16'h1111, res: 16'sd5,
               pulses: SKIP ? 8'd2 : 8'd4, lat: SKIP ? 8'd4 : 8'd6};

    repeat (3) @(negedge clk);
    check("reset:in_ready", bus.in_ready_o, 1);
    check("reset:mac_en", bus.mac_en_o, 0);
    check("reset:out_valid", bus.out_valid_o, 0);
    check("reset:busy", bus.busy_o, 0);
    check("reset:data_p", bus.data_p_o, 0);
    check("reset:result", bus.result_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle:in_ready", bus.in_ready_o, 1);

    for (int i = 0; i < 9; i++) begin
      act_cur = {NR{tbl[i].act_fill}};
      fill_codes(tbl[i].codes);
      set_expect();
      exp_vec    = {NC{tbl[i].res[ACC-1:0]}};
      exp_pulses = int'(tbl[i].pulses);
      exp_lat    = int'(tbl[i].lat);
      run_vec($sformatf("tbl%0d", i), 0, 1'b0);
    end

    // Backpressure: result held 5 cycles while a second vector is offered
    act_cur = {NR{4'hF}};
    fill_codes(16'h3333);
    set_expect();
    run_vec("backpressure", 5, 1'b1);

    // Reset two cycles into COMPUTE, then a clean vector
    bus.in_valid_i = 1'b1;
    bus.act_i      = act_cur;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("midrst:pre_mac_en", bus.mac_en_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst:mac_en", bus.mac_en_o, 0);
    check("midrst:busy", bus.busy_o, 0);
    check("midrst:in_ready", bus.in_ready_o, 1);
    rst = 1'b0;
    act_cur = {NR{4'h6}};
    fill_codes(16'h4321);
    set_expect();
    run_vec("post_rst", 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      pm = IB'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) act_cur[r*IB +: IB] = IB'($urandom()) & pm;
      for (int b = 0; b < IB; b++)
        for (int c = 0; c < NC; c++) codes_tb[b][c] = AB'($urandom());
      set_expect();
      run_vec($sformatf("rnd%0d", n), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
